// File: rtl/tiger_fetch_if.sv
// Instruction-fetch bus bundle.
// Groups the Avalon-MM style instruction memory read port, the redirect
// request from execute, and the instruction handoff to the decoder.
//   imem_address/imem_read        : fetch -> memory read request
//   imem_waitrequest              : memory stall, request held while high
//   imem_readdata/imem_readdatavalid : in-order read responses
//   redirect/redirect_pc          : taken branch/jump, new fetch address
//   instr/instr_pc/instr_valid    : fetched instruction to decoder
//   instr_ready                   : decoder accepts the presented instruction
// master = fetch unit, slave = memory/pipeline environment.
interface tiger_fetch_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;
    logic        imem_readdatavalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_address, imem_read, instr, instr_pc, instr_valid,
        input  imem_waitrequest, imem_readdata, imem_readdatavalid,
               redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_address, imem_read, instr, instr_pc, instr_valid,
        output imem_waitrequest, imem_readdata, imem_readdatavalid,
               redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/tiger_fetch.sv
// tiger_fetch: instruction fetch unit with a 2-entry instruction buffer.
// Issues word-aligned reads to instruction memory, tracks in-flight reads,
// buffers returned words with their PCs, and discards everything fetched
// down the old path when a redirect arrives.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : tiger_fetch_if.master (memory read port, redirect, decoder handoff)
// Parameter:
//   RESET_PC : first fetch address after reset (bits [1:0] ignored)
module tiger_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    tiger_fetch_if.master bus
);
    localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_ret_pc;
    logic [31:0] r_redir_pc;
    logic        r_redir_pend;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_buf_pc    [2];

    logic [31:0] w_redirect_pc;
    logic [2:0]  w_sum;
    logic [2:0]  w_limit;
    logic        w_pop;
    logic        w_req;
    logic        w_accept;
    logic        w_resp;
    logic        w_keep;
    logic        w_tail;

    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    assign w_pop    = !reset && (r_count != 2'd0) && bus.instr_ready;

    // Credit check: outstanding + buffered - popping < 2. Once a request
    // is raised, outstanding+buffered stays <= 1 until it is accepted, so
    // the request can never be withdrawn under waitrequest.
    assign w_sum    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_limit  = 3'd2 + {2'b00, w_pop};
    assign w_req    = !reset && (w_sum < w_limit);
    assign w_accept = w_req && !bus.imem_waitrequest;

    // Responses with nothing outstanding are protocol errors and ignored.
    assign w_resp   = bus.imem_readdatavalid && (r_outstanding != 2'd0);
    assign w_keep   = w_resp && !bus.redirect && (r_drop == 2'd0);

    // Tail slot = head + count (mod 2); with count==2 a push only happens
    // alongside a pop, which frees the head slot.
    assign w_tail   = r_head ^ r_count[0];

    assign bus.imem_read    = w_req;
    assign bus.imem_address = reset ? START_PC : r_fetch_pc;
    assign bus.instr_valid  = !reset && (r_count != 2'd0);
    assign bus.instr        = r_buf_instr[r_head];
    assign bus.instr_pc     = r_buf_pc[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= START_PC;
            r_ret_pc      <= START_PC;
            r_redir_pc    <= START_PC;
            r_redir_pend  <= 1'b0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_head        <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else begin
            // Fetch PC. A redirect that lands on a stalled request is parked
            // until that request is accepted at its original address.
            if (bus.redirect) begin
                if (w_req && bus.imem_waitrequest) begin
                    r_redir_pend <= 1'b1;
                    r_redir_pc   <= w_redirect_pc;
                end else begin
                    r_fetch_pc   <= w_redirect_pc;
                    r_redir_pend <= 1'b0;
                end
            end else if (w_accept) begin
                r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + 32'd4;
                r_redir_pend <= 1'b0;
            end

            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};

            // Every read still in flight at a redirect belongs to the old
            // path; a parked stalled request joins the drop count on accept.
            if (bus.redirect) begin
                r_drop <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
            end else begin
                r_drop <= r_drop + {1'b0, (w_accept && r_redir_pend)}
                                 - {1'b0, (w_resp && (r_drop != 2'd0))};
            end

            if (bus.redirect) begin
                r_ret_pc <= w_redirect_pc;
            end else if (w_keep) begin
                r_ret_pc <= r_ret_pc + 32'd4;
            end

            if (bus.redirect) begin
                r_count <= '0;
            end else begin
                if (w_keep) begin
                    r_buf_instr[w_tail] <= bus.imem_readdata;
                    r_buf_pc[w_tail]    <= r_ret_pc;
                end
                r_count <= r_count + {1'b0, w_keep} - {1'b0, w_pop};
                r_head  <= r_head ^ w_pop;
            end
        end
    end
endmodule

// File: tb/tb_tiger_fetch.sv
// Self-checking bench for tiger_fetch.
// A behavioural memory (random wait states and latency, in-order responses)
// feeds the DUT; a stream model expects the decoder to see consecutive
// word addresses from the last redirect target, with contents from the
// memory function, and nothing from a path abandoned by a redirect.
module tb_tiger_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;

    tiger_fetch_if bus();

    tiger_fetch #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned wait_pct = 0;
    bit          force_wait = 1'b0;

    bit          stall_stale;
    logic [31:0] pend_target;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          buffered;
    bit          prev_stalled;
    logic [31:0] prev_addr;

    logic        s_read, s_valid, s_acc, s_pop;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        mq.delete();
        buffered     = 0;
        exp_pc       = RST_PC;
        exp_req      = RST_PC;
        pend_target  = RST_PC;
        stall_stale  = 1'b0;
        prev_stalled = 1'b0;
        prev_addr    = RST_PC;
    endtask

    // One clock cycle: drive memory side, sample, check against the model.
    task automatic step();
        req_t        r;
        bit          resp;
        bit          resp_stale;
        bit          st;
        int unsigned d;
        logic [31:0] tgt;
        r.addr = '0; r.due = 0; r.stale = 1'b0;
        resp = 1'b0;
        resp_stale = 1'b0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            resp = 1'b1;
            resp_stale = r.stale;
        end
        bus.imem_readdatavalid = resp;
        bus.imem_readdata      = resp ? mem_word(r.addr) : 32'hDEAD_BEEF;
        bus.imem_waitrequest   = force_wait || ($urandom_range(99) < wait_pct);
        #1;
        s_read  = bus.imem_read;
        s_addr  = bus.imem_address;
        s_valid = bus.instr_valid;
        s_instr = bus.instr;
        s_pc    = bus.instr_pc;
        s_acc   = s_read && !bus.imem_waitrequest;
        s_pop   = s_valid && bus.instr_ready;

        checks++;
        if (s_valid !== (buffered != 0)) begin
            failures++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, s_valid, (buffered != 0));
        end
        checks++;
        if (mq.size() + int'(resp) + buffered > 2) begin
            failures++;
            $display("FAIL credit cyc=%0d got=%0d exp<=2", cyc, mq.size() + int'(resp) + buffered);
        end
        if (prev_stalled) begin
            checks++;
            if (s_read !== 1'b1 || s_addr !== prev_addr) begin
                failures++;
                $display("FAIL hold cyc=%0d got read=%b addr=%h exp read=1 addr=%h", cyc, s_read, s_addr, prev_addr);
            end
        end
        if (s_pop) begin
            checks++;
            if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL instr cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, s_pc, s_instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (s_acc) begin
            checks++;
            if (s_addr !== exp_req) begin
                failures++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_req);
            end
            d  = cyc + $urandom_range(lat_max, lat_min);
            st = stall_stale || bus.redirect;
            mq.push_back('{addr: s_addr, due: d, stale: st});
            if (stall_stale) begin
                exp_req = pend_target;
                stall_stale = 1'b0;
            end else begin
                exp_req = exp_req + 32'd4;
            end
        end
        buffered = buffered - (s_pop ? 1 : 0) + ((resp && !resp_stale) ? 1 : 0);
        if (bus.redirect) begin
            tgt = bus.redirect_pc & 32'hFFFF_FFFC;
            foreach (mq[i]) mq[i].stale = 1'b1;
            buffered = 0;
            exp_pc   = tgt;
            if (s_read && bus.imem_waitrequest) begin
                stall_stale = 1'b1;
                pend_target = tgt;
            end else begin
                exp_req     = tgt;
                stall_stale = 1'b0;
            end
        end
        prev_stalled = s_read && bus.imem_waitrequest;
        prev_addr    = s_addr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.imem_readdatavalid = 1'b0;
        bus.imem_waitrequest = 1'b0;
        force_wait = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.imem_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", bus.imem_read); end
        checks++; if (bus.imem_address !== RST_PC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", bus.imem_address, RST_PC); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", bus.instr); end
        checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", bus.instr_pc); end
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (s_read !== 1'b1 || s_addr !== RST_PC) begin
                    failures++;
                    $display("FAIL first_req got read=%b addr=%h exp read=1 addr=%h", s_read, s_addr, RST_PC);
                end
            end
            if (k >= 3) begin
                checks++;
                if (s_valid !== 1'b1 || s_pc !== 32'(4 * (k - 3))) begin
                    failures++;
                    $display("FAIL stream k=%0d got valid=%b pc=%h exp valid=1 pc=%h", k, s_valid, s_pc, 32'(4 * (k - 3)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int pops;
        lat_min = 1; lat_max = 1; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 6; k++) step();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 4) begin
                checks++;
                if (s_read !== 1'b0 || s_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stall k=%0d got read=%b valid=%b exp read=0 valid=1", k, s_read, s_valid);
                end
            end
        end
        bus.instr_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_pop) pops++;
        end
        checks++;
        if (pops < 10) begin
            failures++;
            $display("FAIL bp_resume got pops=%0d exp>=10", pops);
        end
    endtask

    task automatic test_waitrequest();
        lat_min = 1; lat_max = 1; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 1; k <= 4; k++) step();
        force_wait = 1'b1;
        for (int k = 5; k <= 9; k++) begin
            step();
            checks++;
            if (s_read !== 1'b1 || s_addr !== 32'h10) begin
                failures++;
                $display("FAIL wait_hold k=%0d got read=%b addr=%h exp read=1 addr=00000010", k, s_read, s_addr);
            end
        end
        force_wait = 1'b0;
        step();
        checks++;
        if (s_acc !== 1'b1 || s_addr !== 32'h10) begin
            failures++;
            $display("FAIL wait_accept got acc=%b addr=%h exp acc=1 addr=00000010", s_acc, s_addr);
        end
        step();
        checks++;
        if (s_read !== 1'b1 || s_addr !== 32'h14) begin
            failures++;
            $display("FAIL wait_next got read=%b addr=%h exp read=1 addr=00000014", s_read, s_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        lat_min = 3; lat_max = 3; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        step();
        step();
        checks++;
        if (mq.size() != 2) begin
            failures++;
            $display("FAIL inflight got=%0d exp=2", mq.size());
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== 32'h200) begin
            failures++;
            $display("FAIL redir_inflight got found=%b pc=%h exp pc=00000200", found, s_pc);
        end
    endtask

    task automatic test_redirect_stall();
        bit found;
        lat_min = 1; lat_max = 1; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 1; k <= 16; k++) step();
        force_wait = 1'b1;
        for (int k = 17; k <= 20; k++) begin
            if (k == 18) begin
                bus.redirect = 1'b1;
                bus.redirect_pc = 32'h103;
            end
            step();
            bus.redirect = 1'b0;
            checks++;
            if (s_read !== 1'b1 || s_addr !== 32'h40) begin
                failures++;
                $display("FAIL rs_hold k=%0d got read=%b addr=%h exp read=1 addr=00000040", k, s_read, s_addr);
            end
        end
        force_wait = 1'b0;
        step();
        checks++;
        if (s_acc !== 1'b1 || s_addr !== 32'h40) begin
            failures++;
            $display("FAIL rs_accept got acc=%b addr=%h exp acc=1 addr=00000040", s_acc, s_addr);
        end
        step();
        checks++;
        if (s_read !== 1'b1 || s_addr !== 32'h100) begin
            failures++;
            $display("FAIL rs_newreq got read=%b addr=%h exp read=1 addr=00000100", s_read, s_addr);
        end
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== 32'h100) begin
            failures++;
            $display("FAIL rs_first got found=%b pc=%h exp pc=00000100", found, s_pc);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        lat_min = 2; lat_max = 2; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 5; k++) step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect_pc = 32'h500;
        step();
        bus.redirect = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== 32'h500) begin
            failures++;
            $display("FAIL b2b got found=%b pc=%h exp pc=00000500", found, s_pc);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] got  [3];
        logic [31:0] wexp [3];
        int          n_got;
        bit          found;
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        lat_min = 1; lat_max = 1; wait_pct = 0;
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 4; k++) step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        n_got = 0;
        for (int n = 0; n < 30 && n_got < 3; n++) begin
            step();
            if (s_pop) begin
                got[n_got] = s_pc;
                n_got++;
            end
        end
        checks++;
        if (n_got < 3) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=3", n_got);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== wexp[i]) begin
                    failures++;
                    $display("FAIL wrap_pc i=%0d got=%h exp=%h", i, got[i], wexp[i]);
                end
            end
        end
        step();
        reset = 1'b1;
        bus.imem_readdatavalid = 1'b0;
        bus.imem_waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_read !== 1'b0 || bus.imem_address !== RST_PC || bus.instr_valid !== 1'b0 ||
            bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got read=%b addr=%h valid=%b instr=%h pc=%h exp 0/%h/0/0/0",
                     bus.imem_read, bus.imem_address, bus.instr_valid, bus.instr, bus.instr_pc, RST_PC);
        end
        reset = 1'b0;
        model_reset();
        step();
        checks++;
        if (s_read !== 1'b1 || s_addr !== RST_PC) begin
            failures++;
            $display("FAIL refetch got read=%b addr=%h exp read=1 addr=%h", s_read, s_addr, RST_PC);
        end
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== RST_PC) begin
            failures++;
            $display("FAIL refetch_pc got found=%b pc=%h exp=%h", found, s_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        int pops;
        lat_min = 1; lat_max = 4; wait_pct = 25;
        bus.instr_ready = 1'b1;
        apply_reset();
        pops = 0;
        for (int k = 0; k < 3000; k++) begin
            bus.instr_ready = ($urandom_range(99) < 70);
            bus.redirect = ($urandom_range(99) < 4);
            case ($urandom_range(3))
                0:       bus.redirect_pc = $urandom() & 32'h0000_3FFF;
                1:       bus.redirect_pc = s_pc;
                2:       bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
                default: bus.redirect_pc = exp_req;
            endcase
            step();
            if (s_pop) pops++;
        end
        bus.redirect = 1'b0;
        wait_pct = 0;
        checks++;
        if (pops < 300) begin
            failures++;
            $display("FAIL random_progress got pops=%0d exp>=300", pops);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.imem_waitrequest   = 1'b0;
        bus.imem_readdatavalid = 1'b0;
        bus.imem_readdata      = '0;
        bus.redirect           = 1'b0;
        bus.redirect_pc        = '0;
        bus.instr_ready        = 1'b1;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_waitrequest();
        test_redirect_inflight();
        test_redirect_stall();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
